// File: rtl/param_qc_encoder.sv
// Quasi-cyclic systematic encoder: streams a K-bit message in W-bit beats,
// accumulates NP parity bits from circulant first rows, then streams the parity.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for the first message beat of a frame
// ENC    | accepting message beats and folding them into the parity
// PAR    | emitting parity beats, MSB-first, W bits per handshake
module param_qc_encoder #(
    parameter int K  = 1024,
    parameter int NP = 256,
    parameter int B  = 32,
    parameter int W  = 8,
    parameter logic [K*NP/B-1:0] G_ROWS = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode_sys,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy
);

    localparam int NCB       = NP / B;
    localparam int BEATS_IN  = K / W;
    localparam int BEATS_OUT = NP / W;
    localparam int CW_IN     = (BEATS_IN  > 1) ? $clog2(BEATS_IN)  : 1;
    localparam int CW_OUT    = (BEATS_OUT > 1) ? $clog2(BEATS_OUT) : 1;

    localparam logic [CW_IN-1:0]  LAST_IN  = CW_IN'(BEATS_IN - 1);
    localparam logic [CW_OUT-1:0] LAST_OUT = CW_OUT'(BEATS_OUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ENC  = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;

    logic [1:0]        state;
    logic              mode_q;
    logic [CW_IN-1:0]  beat_cnt;
    logic [CW_OUT-1:0] par_cnt;
    logic [NP-1:0]     parity;
    logic [NP-1:0]     contrib;
    logic              eff_mode;
    logic              accept;

    // Parity contribution of one beat. B is a multiple of W, so all W bits of
    // a beat fall in the same circulant row; only the rotation differs per bit.
    function automatic logic [NP-1:0] beat_contrib(input logic [W-1:0] d,
                                                    input logic [CW_IN-1:0] beat);
        logic [NP-1:0]  acc;
        logic [B-1:0]   row;
        logic [2*B-1:0] rot;
        int base;
        int r;
        int j;
        acc  = '0;
        base = int'(beat) * W;
        r    = base / B;
        for (int k = 0; k < W; k++) begin
            j = (base % B) + (W - 1 - k);
            if (d[k]) begin
                for (int c = 0; c < NCB; c++) begin
                    row = G_ROWS[((r * NCB + c) + 1) * B - 1 -: B];
                    rot = {row, row} >> j;
                    acc[NP - 1 - c * B -: B] = acc[NP - 1 - c * B -: B] ^ rot[B-1:0];
                end
            end
        end
        return acc;
    endfunction

    // Before the first beat the live mode pin steers the handshake; afterwards the latched copy.
    always_comb begin
        eff_mode = (state == S_ENC) ? mode_q : mode_sys;
        contrib  = beat_contrib(in_data, beat_cnt);
    end

    // Handshake and data steering for passthrough, parity-only and parity phases.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state)
            S_IDLE, S_ENC: begin
                if (eff_mode) begin
                    in_ready  = out_ready;
                    out_valid = in_valid;
                    out_data  = in_data;
                end else begin
                    in_ready  = 1'b1;
                end
            end
            S_PAR: begin
                out_valid = 1'b1;
                out_data  = parity[NP-1 -: W];
                out_last  = (par_cnt == LAST_OUT);
            end
            default: begin
                in_ready  = 1'b0;
            end
        endcase
        accept = in_valid & in_ready;
        busy   = (state != S_IDLE);
    end

    // Frame sequencing: accumulate parity on accepted beats, shift it out in PAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mode_q   <= 1'b0;
            beat_cnt <= '0;
            par_cnt  <= '0;
            parity   <= '0;
        end else begin
            case (state)
                S_IDLE, S_ENC: begin
                    if (accept) begin
                        parity <= parity ^ contrib;
                        if (state == S_IDLE) begin
                            mode_q <= mode_sys;
                        end
                        if (beat_cnt == LAST_IN) begin
                            beat_cnt <= '0;
                            state    <= S_PAR;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            state    <= S_ENC;
                        end
                    end
                end
                S_PAR: begin
                    if (out_ready) begin
                        if (par_cnt == LAST_OUT) begin
                            par_cnt <= '0;
                            parity  <= '0;
                            state   <= S_IDLE;
                        end else begin
                            par_cnt <= par_cnt + 1'b1;
                            parity  <= parity << W;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_qc_encoder.sv
// Randomized bench for param_qc_encoder with a matrix-level parity reference.
module tb_param_qc_encoder;

    localparam int K  = 16;
    localparam int NP = 8;
    localparam int B  = 4;
    localparam int W  = 2;
    localparam int NCB = NP / B;
    localparam int NB_IN  = K / W;
    localparam int NB_OUT = NP / W;
    // Circulant (0,0)=1000 and (0,1)=0011; remaining rows arbitrary non-zero.
    localparam logic [K*NP/B-1:0] G = 32'hA5C7_1E38;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode_sys;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;

    int n_chk = 0;
    int n_bad = 0;

    param_qc_encoder #(.K(K), .NP(NP), .B(B), .W(W), .G_ROWS(G)) dut (
        .clk(clk), .rst(rst), .mode_sys(mode_sys),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Parity bit at column col = XOR over set message bits of generator entry
    // G[i][col]; circulant column q of row offset j is first-row column (q-j) mod B.
    function automatic logic [NP-1:0] ref_parity(input logic [K-1:0] msg);
        logic [NP-1:0] p;
        p = '0;
        for (int col = 0; col < NP; col++) begin
            int c;
            int q;
            logic acc;
            c   = col / B;
            q   = col % B;
            acc = 1'b0;
            for (int i = 0; i < K; i++) begin
                if (msg[K-1-i]) begin
                    int r;
                    int j;
                    int src;
                    r   = i / B;
                    j   = i % B;
                    src = (q - j + B) % B;
                    acc = acc ^ G[((r * NCB + c) + 1) * B - 1 - src];
                end
            end
            p[NP-1-col] = acc;
        end
        return p;
    endfunction

    task automatic run_frame(input logic [K-1:0] msg, input logic mode,
                             input logic [NP-1:0] exp_par, input int rnd,
                             input int abort_at, input int stall3);
        logic [W-1:0] exp_q[$];
        int sent;
        int got;
        int cyc;
        int n_exp;
        int stall_cnt;
        int sent_before;
        logic prev_stall;
        logic [W-1:0] prev_data;
        exp_q = {};
        if (mode) begin
            for (int b = 0; b < NB_IN; b++) exp_q.push_back(msg[K-1-b*W -: W]);
        end
        for (int p = 0; p < NB_OUT; p++) exp_q.push_back(exp_par[NP-1-p*W -: W]);
        n_exp = exp_q.size();
        sent = 0; got = 0; cyc = 0; stall_cnt = 0;
        prev_stall = 1'b0; prev_data = '0;
        while (got < n_exp && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (abort_at >= 0 && got == abort_at) begin
                rst       = 1'b1;
                in_valid  = (sent < NB_IN);
                in_data   = (sent < NB_IN) ? msg[K-1-sent*W -: W] : '0;
                out_ready = 1'b1;
                @(negedge clk);
                rst      = 1'b0;
                in_valid = 1'b0;
                #1;
                check_eq("abort_busy", 32'(busy), 32'd0);
                check_eq("abort_oval", 32'(out_valid), 32'd0);
                check_eq("abort_last", 32'(out_last), 32'd0);
                return;
            end
            in_valid  = (sent < NB_IN) && ((rnd != 0) ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_data   = in_valid ? msg[K-1-sent*W -: W] : W'($urandom);
            mode_sys  = (sent == 0) ? mode : 1'($urandom);
            out_ready = (rnd != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall3 != 0 && sent == NB_IN && got == n_exp - 3 && stall_cnt < 3) begin
                out_ready = 1'b0;
                stall_cnt++;
            end
            #1;
            sent_before = sent;
            check_eq("busy", 32'(busy), 32'(sent_before > 0));
            if (prev_stall) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (sent_before < NB_IN) begin
                check_eq("in_ready", 32'(in_ready), mode ? 32'(out_ready) : 32'd1);
                if (!mode) check_eq("quiet", 32'(out_valid), 32'd0);
            end else begin
                check_eq("par_irdy", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                check_eq("beat", 32'(out_data), 32'(exp_q[got]));
                check_eq("last", 32'(out_last), 32'(got == n_exp - 1));
                got++;
            end
            if (in_valid && in_ready) sent++;
            prev_stall = out_valid && !out_ready && (sent_before == NB_IN);
            prev_data  = out_data;
        end
        check_eq("done", 32'(got), 32'(n_exp));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_oval", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [K-1:0] m;
        logic md;
        rst = 1'b1; mode_sys = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_oval", 32'(out_valid), 32'd0);
        check_eq("rst_last", 32'(out_last), 32'd0);
        check_eq("rst_irdy", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        #1;
        check_eq("idle_irdy_pass", 32'(in_ready), 32'd0);
        mode_sys = 1'b0;
        #1;
        check_eq("idle_irdy_par", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        mode_sys = 1'b1;

        run_frame(16'h0000, 1'b1, 8'h00,       0, -1, 0);
        run_frame(16'h8000, 1'b1, 8'b10000011, 0, -1, 0);
        run_frame(16'h4000, 1'b1, 8'b01001001, 0, -1, 0);
        run_frame(16'h8000, 1'b0, 8'b10000011, 0, -1, 0);

        m = K'($urandom);
        run_frame(m, 1'b1, ref_parity(m), 1, -1, 1);
        m = K'($urandom);
        run_frame(m, 1'b1, ref_parity(m), 0, 4, 0);
        m = K'($urandom);
        run_frame(m, 1'b1, ref_parity(m), 0, -1, 0);
        m = K'($urandom);
        run_frame(m, 1'b1, ref_parity(m), 0, NB_IN + 2, 0);
        m = K'($urandom);
        run_frame(m, 1'b0, ref_parity(m), 1, -1, 0);

        for (int f = 0; f < 20; f++) begin
            m  = K'($urandom);
            md = 1'($urandom);
            run_frame(m, md, ref_parity(m), 1, -1, f % 3);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
